// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline sequencing controller for the 5-stage CPU. Produces
//               PC write enable, IF/ID stall/flush, ID/EX bubble insertion
//               and a global hold for ID/EX, EX/MEM and MEM/WB. Handles
//               load-use hazards, taken branches resolved in ID and
//               multi-cycle data-memory accesses with a timeout.
//               Optional feature macro: HAZARD_PERF_EN (stall/flush
//               performance counters; ports are tied to 0 when undefined).
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 16,   // legal range 2..255
    parameter int CNT_W       = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,            // asynchronous, active low
    input  logic                  start_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_uses_rs2_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  ex_memread_i,
    input  logic                  id_branch_taken_i,
    input  logic                  mem_req_i,
    input  logic                  mem_ack_i,
    output logic                  pc_write_o,
    output logic                  if_id_stall_o,
    output logic                  if_id_flush_o,
    output logic                  id_ex_bubble_o,
    output logic                  pipe_hold_o,
    output logic                  err_o,
    output logic [1:0]            state_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_MEM_WAIT = 2'd2,
        S_ERROR    = 2'd3
    } state_t;

    // Last wait count value before the access is declared lost.
    localparam logic [7:0] c_WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_wait_cnt;
    logic [7:0] w_wait_cnt_nxt;

    logic w_load_use;
    logic w_mem_pending;
    logic w_rs1_match;
    logic w_rs2_match;

    // Load in EX writes a register the ID instruction reads; x0 never hazards.
    assign w_rs1_match   = (ex_rd_i == id_rs1_i);
    assign w_rs2_match   = id_uses_rs2_i & (ex_rd_i == id_rs2_i);
    assign w_load_use    = ex_memread_i & (ex_rd_i != '0) & (w_rs1_match | w_rs2_match);

    // A request that is not acknowledged in its issue cycle needs a wait.
    assign w_mem_pending = mem_req_i & ~mem_ack_i;

    assign state_o = r_state;

    // State and wait counter registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    // Mealy decode of outputs and next state; the frozen pipeline is the default.
    always_comb begin
        pc_write_o     = 1'b0;
        if_id_stall_o  = 1'b1;
        if_id_flush_o  = 1'b0;
        id_ex_bubble_o = 1'b0;
        pipe_hold_o    = 1'b1;
        err_o          = 1'b0;
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;

        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_nxt = S_RUN;
                end
            end

            S_RUN: begin
                if (w_mem_pending) begin
                    // Whole pipeline freezes until the data memory answers.
                    w_state_nxt    = S_MEM_WAIT;
                    w_wait_cnt_nxt = 8'd0;
                end else begin
                    pipe_hold_o = 1'b0;
                    if (w_load_use) begin
                        // Hold IF/ID and PC one cycle; the load moves on to
                        // MEM so the hazard is gone next cycle. A taken
                        // branch here is dropped and re-resolves next cycle.
                        id_ex_bubble_o = 1'b1;
                    end else if (id_branch_taken_i) begin
                        pc_write_o    = 1'b1;
                        if_id_stall_o = 1'b0;
                        if_id_flush_o = 1'b1;
                    end else begin
                        pc_write_o    = 1'b1;
                        if_id_stall_o = 1'b0;
                    end
                    if (!start_i) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end

            S_MEM_WAIT: begin
                if (mem_ack_i) begin
                    // Release every hold in the ack cycle itself. start_i
                    // is only looked at here, never earlier in the wait.
                    pc_write_o     = 1'b1;
                    if_id_stall_o  = 1'b0;
                    pipe_hold_o    = 1'b0;
                    w_wait_cnt_nxt = 8'd0;
                    w_state_nxt    = start_i ? S_RUN : S_IDLE;
                end else if (r_wait_cnt == c_WAIT_LAST) begin
                    w_state_nxt = S_ERROR;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                end
            end

            S_ERROR: begin
                // Sticky until reset.
                err_o = 1'b1;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef HAZARD_PERF_EN
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_stall_evt;

    // Stalls count only while the CPU is actually running or waiting.
    assign w_stall_evt = ((r_state == S_RUN) | (r_state == S_MEM_WAIT)) & if_id_stall_o;

    // Saturating stall and flush event counters.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_evt && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            end
            if (if_id_flush_o && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl. A behavioural model of
//               the sequencing rules is checked against the DUT every cycle,
//               with directed scenarios pinned by literal expectations and a
//               randomized phase. Honours HAZARD_PERF_EN for the counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int REG_ADDR_W  = 5;
    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 32;

    logic                  clk_i = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  start_i = 1'b0;
    logic [REG_ADDR_W-1:0] id_rs1_i = '0;
    logic [REG_ADDR_W-1:0] id_rs2_i = '0;
    logic                  id_uses_rs2_i = 1'b0;
    logic [REG_ADDR_W-1:0] ex_rd_i = '0;
    logic                  ex_memread_i = 1'b0;
    logic                  id_branch_taken_i = 1'b0;
    logic                  mem_req_i = 1'b0;
    logic                  mem_ack_i = 1'b0;
    logic                  pc_write_o;
    logic                  if_id_stall_o;
    logic                  if_id_flush_o;
    logic                  id_ex_bubble_o;
    logic                  pipe_hold_o;
    logic                  err_o;
    logic [1:0]            state_o;
    logic [CNT_W-1:0]      stall_cnt_o;
    logic [CNT_W-1:0]      flush_cnt_o;

    always #5 clk_i = ~clk_i;

    hazard_ctrl #(
        .REG_ADDR_W (REG_ADDR_W),
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) u_dut (
        .clk_i            (clk_i),
        .rst_i            (rst_n),
        .start_i          (start_i),
        .id_rs1_i         (id_rs1_i),
        .id_rs2_i         (id_rs2_i),
        .id_uses_rs2_i    (id_uses_rs2_i),
        .ex_rd_i          (ex_rd_i),
        .ex_memread_i     (ex_memread_i),
        .id_branch_taken_i(id_branch_taken_i),
        .mem_req_i        (mem_req_i),
        .mem_ack_i        (mem_ack_i),
        .pc_write_o       (pc_write_o),
        .if_id_stall_o    (if_id_stall_o),
        .if_id_flush_o    (if_id_flush_o),
        .id_ex_bubble_o   (id_ex_bubble_o),
        .pipe_hold_o      (pipe_hold_o),
        .err_o            (err_o),
        .state_o          (state_o),
        .stall_cnt_o      (stall_cnt_o),
        .flush_cnt_o      (flush_cnt_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic pc;
        logic stall;
        logic flush;
        logic bubble;
        logic hold;
        logic err;
    } ctl_t;

    int               m_mode   = 0;   // 0 idle, 1 run, 2 waiting on memory, 3 error
    int               m_waited = 0;   // unacknowledged waiting cycles so far
    logic [CNT_W-1:0] m_stall  = '0;
    logic [CNT_W-1:0] m_flush  = '0;

    function automatic logic f_lu();
        return ex_memread_i && (ex_rd_i != 0) &&
               ((ex_rd_i == id_rs1_i) || (id_uses_rs2_i && (ex_rd_i == id_rs2_i)));
    endfunction

    // Control outputs implied by the current mode and the live inputs.
    function automatic ctl_t f_expect(input int mode);
        ctl_t frozen;
        ctl_t free_run;
        frozen   = '{pc: 1'b0, stall: 1'b1, flush: 1'b0, bubble: 1'b0, hold: 1'b1, err: 1'b0};
        free_run = '{pc: 1'b1, stall: 1'b0, flush: 1'b0, bubble: 1'b0, hold: 1'b0, err: 1'b0};
        if (mode == 1) begin
            if (mem_req_i && !mem_ack_i) return frozen;
            if (f_lu())
                return '{pc: 1'b0, stall: 1'b1, flush: 1'b0, bubble: 1'b1, hold: 1'b0, err: 1'b0};
            if (id_branch_taken_i)
                return '{pc: 1'b1, stall: 1'b0, flush: 1'b1, bubble: 1'b0, hold: 1'b0, err: 1'b0};
            return free_run;
        end
        if (mode == 2) return mem_ack_i ? free_run : frozen;
        if (mode == 3) frozen.err = 1'b1;
        return frozen;
    endfunction

    always @(posedge clk_i or negedge rst_n) begin : p_model
        ctl_t c;
        if (!rst_n) begin
            m_mode   <= 0;
            m_waited <= 0;
            m_stall  <= '0;
            m_flush  <= '0;
        end else begin
            c = f_expect(m_mode);
            if ((m_mode == 1 || m_mode == 2) && c.stall && (m_stall != '1)) m_stall <= m_stall + 1;
            if (c.flush && (m_flush != '1)) m_flush <= m_flush + 1;
            if (m_mode == 0) begin
                if (start_i) m_mode <= 1;
            end else if (m_mode == 1) begin
                if (mem_req_i && !mem_ack_i) begin
                    m_mode   <= 2;
                    m_waited <= 0;
                end else if (!start_i) begin
                    m_mode <= 0;
                end
            end else if (m_mode == 2) begin
                if (mem_ack_i)                          m_mode <= start_i ? 1 : 0;
                else if (m_waited + 1 >= MEM_TIMEOUT)   m_mode <= 3;
                else                                    m_waited <= m_waited + 1;
            end
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk_i) begin : p_compare
        ctl_t e;
        e = f_expect(m_mode);
        chk("pc_write",  pc_write_o,     e.pc);
        chk("stall",     if_id_stall_o,  e.stall);
        chk("flush",     if_id_flush_o,  e.flush);
        chk("bubble",    id_ex_bubble_o, e.bubble);
        chk("hold",      pipe_hold_o,    e.hold);
        chk("err",       err_o,          e.err);
        chk("state",     state_o,        64'(m_mode));
        chk("stall_and_flush", if_id_stall_o & if_id_flush_o, 0);
`ifdef HAZARD_PERF_EN
        chk("stall_cnt", stall_cnt_o, m_stall);
        chk("flush_cnt", flush_cnt_o, m_flush);
`else
        chk("stall_cnt_tied", stall_cnt_o, 0);
        chk("flush_cnt_tied", flush_cnt_o, 0);
`endif
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic mid();
        @(negedge clk_i);
    endtask

    task automatic clear_in();
        ex_memread_i      = 1'b0;
        ex_rd_i           = '0;
        id_rs1_i          = '0;
        id_rs2_i          = '0;
        id_uses_rs2_i     = 1'b0;
        id_branch_taken_i = 1'b0;
        mem_req_i         = 1'b0;
        mem_ack_i         = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        mid();
        chk("rst_state", state_o, 0);
        chk("rst_stall", if_id_stall_o, 1);
        chk("rst_hold",  pipe_hold_o, 1);
        chk("rst_pc",    pc_write_o, 0);

        // Start: one IDLE cycle, then RUN
        tick();
        rst_n   = 1'b1;
        start_i = 1'b1;
        mid();
        chk("idle_state", state_o, 0);
        chk("idle_stall", if_id_stall_o, 1);
        chk("idle_hold",  pipe_hold_o, 1);
        tick(); mid();
        chk("run_state", state_o, 1);
        chk("run_pc",    pc_write_o, 1);
        chk("run_stall", if_id_stall_o, 0);

        // Load-use on rs2
        tick();
        ex_memread_i = 1'b1; ex_rd_i = 5'd5; id_rs2_i = 5'd5; id_uses_rs2_i = 1'b1; id_rs1_i = 5'd3;
        mid();
        chk("lu_stall",  if_id_stall_o, 1);
        chk("lu_bubble", id_ex_bubble_o, 1);
        chk("lu_pc",     pc_write_o, 0);
        tick();
        ex_memread_i = 1'b0;
        mid();
        chk("lu_gone_stall", if_id_stall_o, 0);
        // Load into x0 never hazards
        tick();
        ex_memread_i = 1'b1; ex_rd_i = '0; id_rs2_i = '0;
        mid();
        chk("lu_x0_stall", if_id_stall_o, 0);

        // Taken branch alone, then with load-use
        tick();
        clear_in();
        id_branch_taken_i = 1'b1;
        mid();
        chk("br_flush", if_id_flush_o, 1);
        chk("br_pc",    pc_write_o, 1);
        tick();
        ex_memread_i = 1'b1; ex_rd_i = 5'd7; id_rs1_i = 5'd7;
        mid();
        chk("br_lu_flush",  if_id_flush_o, 0);
        chk("br_lu_bubble", id_ex_bubble_o, 1);

        // Memory wait with ack three cycles after the request
        tick();
        clear_in();
        mem_req_i = 1'b1;
        mid();
        chk("mw_hold0", pipe_hold_o, 1);
        tick(); mid();
        chk("mw_state1", state_o, 2);
        chk("mw_hold1",  pipe_hold_o, 1);
        tick(); mid();
        chk("mw_hold2", pipe_hold_o, 1);
        tick();
        mem_ack_i = 1'b1;
        mid();
        chk("mw_ack_hold",  pipe_hold_o, 0);
        chk("mw_ack_stall", if_id_stall_o, 0);
        tick();
        clear_in();
        mid();
        chk("mw_back_run", state_o, 1);

        // Zero-wait access
        tick();
        mem_req_i = 1'b1; mem_ack_i = 1'b1;
        mid();
        chk("zw_hold", pipe_hold_o, 0);
        tick();
        clear_in();
        mid();
        chk("zw_state", state_o, 1);

        // Timeout: one RUN cycle plus MEM_TIMEOUT waiting cycles
        tick();
        mem_req_i = 1'b1;
        repeat (MEM_TIMEOUT) tick();
        mid();
        chk("to_last_wait", state_o, 2);
        tick(); mid();
        chk("to_state", state_o, 3);
        chk("to_err",   err_o, 1);
        tick();
        clear_in();
        start_i = 1'b0;
        repeat (5) tick();
        mid();
        chk("to_sticky", err_o, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("to_rst_state", state_o, 0);
        chk("to_rst_err",   err_o, 0);

        // Reset in the middle of a memory wait
        tick();
        rst_n   = 1'b1;
        start_i = 1'b1;
        tick();
        mem_req_i = 1'b1;
        tick(); tick();
        mid();
        chk("abort_pre", state_o, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_state", state_o, 0);
        chk("abort_hold",  pipe_hold_o, 1);
        tick();
        rst_n = 1'b1;
        clear_in();

        // Randomized phase
        for (int i = 0; i < 4000; i++) begin
            int ack_pct;
            tick();
            ack_pct = (i >= 2000 && i < 2600) ? 4 : 40;
            rst_n = !(((m_mode == 3) && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 499) == 0));
            start_i           = ($urandom_range(0, 99) < 92);
            id_rs1_i          = REG_ADDR_W'($urandom_range(0, 3));
            id_rs2_i          = REG_ADDR_W'($urandom_range(0, 3));
            ex_rd_i           = REG_ADDR_W'($urandom_range(0, 3));
            id_uses_rs2_i     = $urandom_range(0, 1) == 1;
            ex_memread_i      = ($urandom_range(0, 99) < 30);
            id_branch_taken_i = ($urandom_range(0, 99) < 25);
            mem_req_i         = ($urandom_range(0, 99) < 25);
            mem_ack_i         = ($urandom_range(0, 99) < ack_pct);
        end
        tick();
        mid();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
